// File: rtl/frame_sink.sv
// Frame sink: checks pixel-stream geometry and writes pixels to a frame-buffer port.
// Latency: a pixel accepted in cycle N is presented on mem_* in cycle N+1.
// Backpressure: ready drops only while the one-entry hold slot is full and mem_busy is high.
module frame_sink #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int RBG_SIZE   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  input  logic                  first,
  input  logic                  last_x,
  input  logic                  last_y,
  input  logic                  valid,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [RBG_SIZE-1:0]   mem_data,
  output logic                  mem_we,
  input  logic                  mem_busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  sync_error,
  input  logic                  error_clr
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam bit SINGLE = (IMG_WIDTH == 1) && (IMG_HEIGHT == 1);
  // Position that follows (0,0): next column, or next line for one-pixel-wide images.
  localparam logic [XW-1:0] X_AFTER0 = (IMG_WIDTH > 1) ? XW'(1) : '0;
  localparam logic [YW-1:0] Y_AFTER0 = (IMG_WIDTH > 1 || SINGLE) ? '0 : YW'(1);

  typedef enum logic {SYNC, ACTIVE} state_t;

  typedef struct packed {
    logic                  vld;
    logic                  last;
    logic [ADDR_WIDTH-1:0] addr;
    logic [RBG_SIZE-1:0]   dat;
  } hold_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  hold_t                 hold_q;
  logic                  load, load_last, err_set;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic                  frame_done_q, sync_error_q;
  logic [15:0]           frame_count_q;
  logic                  xfer, wr_done, at_eol, at_eof, chk_ok;

  assign ready   = !reset && (!hold_q.vld || !mem_busy);
  assign xfer    = valid && ready;
  assign wr_done = hold_q.vld && !mem_busy;
  assign at_eol  = (x_q == X_LAST);
  assign at_eof  = at_eol && (y_q == Y_LAST);
  assign chk_ok  = !first && (last_x == at_eol) && (last_y == at_eof);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    load      = 1'b0;
    load_addr = addr_q;
    load_last = 1'b0;
    err_set   = 1'b0;
    if (xfer) begin
      if (state_q == ACTIVE && chk_ok) begin
        load      = 1'b1;
        load_last = at_eof;
        if (at_eof) begin
          state_d = SYNC;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else if (at_eol) begin
          x_d    = '0;
          y_d    = y_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end else begin
          x_d    = x_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end else if (first) begin
        // Start of frame, or immediate resync when it arrives mid-frame.
        err_set   = (state_q == ACTIVE);
        load      = 1'b1;
        load_addr = '0;
        load_last = SINGLE;
        state_d   = SINGLE ? SYNC : ACTIVE;
        x_d       = X_AFTER0;
        y_d       = Y_AFTER0;
        addr_d    = SINGLE ? '0 : ADDR_WIDTH'(1);
      end else begin
        err_set = (state_q == ACTIVE);
        state_d = SYNC;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      hold_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      sync_error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      if (load) begin
        hold_q <= '{vld: 1'b1, last: load_last, addr: load_addr, dat: RBG_SIZE'({b, g, r})};
      end else if (wr_done) begin
        hold_q.vld <= 1'b0;
      end
      frame_done_q <= wr_done && hold_q.last;
      if (wr_done && hold_q.last) frame_count_q <= frame_count_q + 16'd1;
      if (err_set) sync_error_q <= 1'b1;
      else if (error_clr) sync_error_q <= 1'b0;
    end
  end

  assign mem_we      = hold_q.vld;
  assign mem_addr    = hold_q.addr;
  assign mem_data    = hold_q.dat;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign sync_error  = sync_error_q;

endmodule
